// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: single-word req/ack bus access,
// pipeline stall, MEM/WB register and fault reporting.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MEM_PC_p4,
   input  logic [31:0] MEM_alu_out,
   input  logic [31:0] MEM_rt_data,
   input  logic [4:0]  MEM_Rd,
   input  logic [1:0]  MEM_MemToReg,
   input  logic        MEM_MemWrite,
   input  logic        MEM_MemRead,
   input  logic        MEM_RegWrite,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic [31:0] WB_PC_p4,
   output logic [31:0] WB_alu_out,
   output logic [31:0] WB_mem_data,
   output logic [31:0] WB_wr_data,
   output logic [4:0]  WB_Rd,
   output logic [1:0]  WB_MemToReg,
   output logic        WB_RegWrite,
   output logic        err,
   output logic [31:0] err_pc
);

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } state_t;

   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;

   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_wb_pc_p4;
   logic [31:0] r_wb_alu_out;
   logic [31:0] r_wb_mem_data;
   logic [31:0] r_wb_wr_data;
   logic [4:0]  r_wb_rd;
   logic [1:0]  r_wb_mem_to_reg;
   logic        r_wb_reg_write;
   logic        r_err;
   logic [31:0] r_err_pc;

   logic        w_mem_op;
   logic        w_aligned;
   logic        w_timeout;
   logic        w_issue;
   logic        w_done;
   logic        w_fault;
   logic        w_pass;
   logic        w_wait;
   logic        w_stall;
   logic [31:0] w_mem_data;
   logic [31:0] w_wr_data;

   assign w_mem_op  = MEM_MemRead | MEM_MemWrite;
   assign w_aligned = (MEM_alu_out[1:0] == 2'b00);
   assign w_timeout = (r_cnt == LP_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      w_fault     = 1'b0;
      w_pass      = 1'b0;
      w_wait      = 1'b0;
      w_stall     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_mem_op) begin
               w_pass = 1'b1;
            end else if (w_aligned) begin
               w_issue     = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = S_ACCESS;
            end else begin
               w_fault = 1'b1;
            end
         end
         S_ACCESS: begin
            // ack beats a simultaneous timeout
            if (bus_ack) begin
               w_done      = 1'b1;
               w_pass      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_fault     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_wait  = 1'b1;
               w_stall = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign stall = w_stall & ~reset;

   assign w_mem_data =
      (w_done && !MEM_MemWrite) ? bus_rdata : 32'h0;

   always_comb begin
      case (MEM_MemToReg)
         2'b01:   w_wr_data = w_mem_data;
         2'b10:   w_wr_data = MEM_PC_p4;
         default: w_wr_data = MEM_alu_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_IDLE;
         r_cnt           <= 16'h0;
         r_bus_req       <= 1'b0;
         r_bus_we        <= 1'b0;
         r_bus_addr      <= 32'h0;
         r_bus_wdata     <= 32'h0;
         r_wb_pc_p4      <= 32'h0;
         r_wb_alu_out    <= 32'h0;
         r_wb_mem_data   <= 32'h0;
         r_wb_wr_data    <= 32'h0;
         r_wb_rd         <= 5'h0;
         r_wb_mem_to_reg <= 2'h0;
         r_wb_reg_write  <= 1'b0;
         r_err           <= 1'b0;
         r_err_pc        <= 32'h0;
      end else begin
         r_state <= w_state_nxt;

         if (w_issue) begin
            r_cnt       <= 16'h0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= MEM_MemWrite;
            r_bus_addr  <= {MEM_alu_out[31:2], 2'b00};
            r_bus_wdata <= MEM_rt_data;
         end else if (w_wait) begin
            r_cnt <= r_cnt + 16'h1;
         end else if (r_state == S_ACCESS) begin
            r_bus_req <= 1'b0;
         end

         // anything not passed through becomes a bubble
         if (w_pass) begin
            r_wb_pc_p4      <= MEM_PC_p4;
            r_wb_alu_out    <= MEM_alu_out;
            r_wb_mem_data   <= w_mem_data;
            r_wb_wr_data    <= w_wr_data;
            r_wb_rd         <= MEM_Rd;
            r_wb_mem_to_reg <= MEM_MemToReg;
            r_wb_reg_write  <= MEM_RegWrite;
         end else begin
            r_wb_pc_p4      <= 32'h0;
            r_wb_alu_out    <= 32'h0;
            r_wb_mem_data   <= 32'h0;
            r_wb_wr_data    <= 32'h0;
            r_wb_rd         <= 5'h0;
            r_wb_mem_to_reg <= 2'h0;
            r_wb_reg_write  <= 1'b0;
         end

         r_err <= w_fault;
         if (w_fault) begin
            r_err_pc <= MEM_PC_p4 - 32'd4;
         end
      end
   end

   assign bus_req     = r_bus_req;
   assign bus_we      = r_bus_we;
   assign bus_addr    = r_bus_addr;
   assign bus_wdata   = r_bus_wdata;
   assign WB_PC_p4    = r_wb_pc_p4;
   assign WB_alu_out  = r_wb_alu_out;
   assign WB_mem_data = r_wb_mem_data;
   assign WB_wr_data  = r_wb_wr_data;
   assign WB_Rd       = r_wb_rd;
   assign WB_MemToReg = r_wb_mem_to_reg;
   assign WB_RegWrite = r_wb_reg_write;
   assign err         = r_err;
   assign err_pc      = r_err_pc;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu: per-instruction outcome
// model predicts every cycle's stall and MEM/WB/bus/err state.
module tb_mem_stage_lsu;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] MEM_PC_p4 = '0;
   logic [31:0] MEM_alu_out = '0;
   logic [31:0] MEM_rt_data = '0;
   logic [4:0]  MEM_Rd = '0;
   logic [1:0]  MEM_MemToReg = '0;
   logic        MEM_MemWrite = 1'b0;
   logic        MEM_MemRead = 1'b0;
   logic        MEM_RegWrite = 1'b0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        stall;
   logic [31:0] WB_PC_p4;
   logic [31:0] WB_alu_out;
   logic [31:0] WB_mem_data;
   logic [31:0] WB_wr_data;
   logic [4:0]  WB_Rd;
   logic [1:0]  WB_MemToReg;
   logic        WB_RegWrite;
   logic        err;
   logic [31:0] err_pc;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .MEM_PC_p4(MEM_PC_p4),
      .MEM_alu_out(MEM_alu_out),
      .MEM_rt_data(MEM_rt_data),
      .MEM_Rd(MEM_Rd),
      .MEM_MemToReg(MEM_MemToReg),
      .MEM_MemWrite(MEM_MemWrite),
      .MEM_MemRead(MEM_MemRead),
      .MEM_RegWrite(MEM_RegWrite),
      .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall(stall),
      .WB_PC_p4(WB_PC_p4),
      .WB_alu_out(WB_alu_out),
      .WB_mem_data(WB_mem_data),
      .WB_wr_data(WB_wr_data),
      .WB_Rd(WB_Rd),
      .WB_MemToReg(WB_MemToReg),
      .WB_RegWrite(WB_RegWrite),
      .err(err), .err_pc(err_pc)
   );

   always #5 clk = ~clk;

   // stall: this cycle; the rest: state after this cycle's edge
   typedef struct {
      logic        stall;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] md;
      logic [31:0] wd;
      logic [4:0]  rd;
      logic [1:0]  m2r;
      logic        rw;
      logic        err;
      logic [31:0] errpc;
   } rec_t;

   rec_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_errpc = '0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic rec_t bubble();
      rec_t r;
      r = '{default: '0};
      r.errpc = m_errpc;
      return r;
   endfunction

   function automatic logic [31:0] sel(
      input logic [1:0]  m2r,
      input logic [31:0] alu, md, pc4);
      if (m2r == 2'b01) return md;
      if (m2r == 2'b10) return pc4;
      return alu;
   endfunction

   task automatic step(input rec_t r);
      exp_q.push_back(r);
      @(posedge clk);
      #2;
   endtask

   // L = bus wait cycles before ack; L >= T means no ack
   task automatic run_instr(
      input logic [31:0] pc4, alu, rt,
      input logic [4:0]  rd,
      input logic [1:0]  m2r,
      input logic        mw, mr, rw,
      input int          L,
      input logic        ack_idle,
      input logic [31:0] rdv);
      rec_t        r;
      logic [31:0] md;
      reset        = 1'b0;
      MEM_PC_p4    = pc4;
      MEM_alu_out  = alu;
      MEM_rt_data  = rt;
      MEM_Rd       = rd;
      MEM_MemToReg = m2r;
      MEM_MemWrite = mw;
      MEM_MemRead  = mr;
      MEM_RegWrite = rw;
      bus_ack      = ack_idle;
      bus_rdata    = $urandom;
      if (!(mr | mw)) begin
         r = bubble();
         r.pc4 = pc4; r.alu = alu;
         r.rd = rd; r.m2r = m2r; r.rw = rw;
         r.wd = sel(m2r, alu, 32'h0, pc4);
         step(r);
      end else if (alu[1:0] != 2'b00) begin
         m_errpc = pc4 - 32'd4;
         r = bubble();
         r.err = 1'b1;
         step(r);
      end else begin
         r = bubble();
         r.stall = 1'b1; r.req = 1'b1; r.we = mw;
         r.addr = {alu[31:2], 2'b00}; r.wdata = rt;
         step(r);
         for (int j = 0; j < T; j++) begin
            bus_ack   = (j == L);
            bus_rdata = (j == L) ? rdv : 32'($urandom);
            if (j == L) begin
               md = mw ? 32'h0 : rdv;
               r = bubble();
               r.pc4 = pc4; r.alu = alu;
               r.rd = rd; r.m2r = m2r; r.rw = rw;
               r.md = md;
               r.wd = sel(m2r, alu, md, pc4);
               step(r);
               break;
            end else if (j == T - 1) begin
               m_errpc = pc4 - 32'd4;
               r = bubble();
               r.err = 1'b1;
               step(r);
            end else begin
               r = bubble();
               r.stall = 1'b1; r.req = 1'b1; r.we = mw;
               r.addr = {alu[31:2], 2'b00}; r.wdata = rt;
               step(r);
            end
         end
      end
      bus_ack = 1'b0;
   endtask

   // compare: stall of the current cycle, outputs of the last edge
   initial begin
      rec_t prev;
      rec_t cur;
      prev = '{default: '0};
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("stall", stall, cur.stall);
            chk("bus_req", bus_req, prev.req);
            if (prev.req) begin
               chk("bus_addr", bus_addr, prev.addr);
               chk("bus_we", bus_we, prev.we);
               chk("bus_wdata", bus_wdata, prev.wdata);
            end
            chk("WB_PC_p4", WB_PC_p4, prev.pc4);
            chk("WB_alu_out", WB_alu_out, prev.alu);
            chk("WB_mem_data", WB_mem_data, prev.md);
            chk("WB_wr_data", WB_wr_data, prev.wd);
            chk("WB_Rd", WB_Rd, prev.rd);
            chk("WB_MemToReg", WB_MemToReg, prev.m2r);
            chk("WB_RegWrite", WB_RegWrite, prev.rw);
            chk("err", err, prev.err);
            chk("err_pc", err_pc, prev.errpc);
            prev = cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t        r;
      int          k;
      logic [31:0] a;
      reset   = 1'b1;
      bus_ack = 1'b1;
      @(posedge clk);
      #2;
      r = bubble();
      step(r);
      step(r);

      run_instr(32'h10, 32'h1234, 32'h0, 5'd5, 2'b00,
                1'b0, 1'b0, 1'b1, 0, 1'b1, 32'h0);
      chk("lit_alu_wd", WB_wr_data, 32'h1234);
      chk("lit_alu_rd", WB_Rd, 32'd5);

      run_instr(32'h14, 32'h100, 32'h0, 5'd7, 2'b01,
                1'b0, 1'b1, 1'b1, 2, 1'b0, 32'hDEADBEEF);
      chk("lit_ld_wd", WB_wr_data, 32'hDEADBEEF);
      chk("lit_ld_md", WB_mem_data, 32'hDEADBEEF);

      run_instr(32'h18, 32'h204, 32'hCAFEF00D, 5'd0, 2'b00,
                1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h55);
      chk("lit_st_md", WB_mem_data, 32'h0);
      chk("lit_st_wd", WB_wr_data, 32'h204);

      run_instr(32'h40, 32'h102, 32'h0, 5'd3, 2'b01,
                1'b0, 1'b1, 1'b1, 0, 1'b1, 32'h0);
      chk("lit_mis_err", err, 32'd1);
      chk("lit_mis_pc", err_pc, 32'h3C);
      chk("lit_mis_rw", WB_RegWrite, 32'd0);

      run_instr(32'h50, 32'h400, 32'h0, 5'd4, 2'b01,
                1'b0, 1'b1, 1'b1, T + 1, 1'b0, 32'h0);
      chk("lit_to_err", err, 32'd1);
      chk("lit_to_pc", err_pc, 32'h4C);
      run_instr(32'h54, 32'h8, 32'h0, 5'd1, 2'b00,
                1'b0, 1'b0, 1'b1, 0, 1'b1, 32'h0);
      chk("lit_late_err", err, 32'd0);
      chk("lit_late_req", bus_req, 32'd0);

      run_instr(32'h60, 32'h500, 32'h0, 5'd2, 2'b01,
                1'b0, 1'b1, 1'b1, T - 1, 1'b0, 32'h77);
      chk("lit_race_wd", WB_wr_data, 32'h77);
      chk("lit_race_err", err, 32'd0);

      // reset while a load waits on the bus
      MEM_PC_p4 = 32'h70; MEM_alu_out = 32'h300;
      MEM_Rd = 5'd9; MEM_MemToReg = 2'b01;
      MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
      MEM_RegWrite = 1'b1; bus_ack = 1'b0;
      r = bubble();
      r.stall = 1'b1; r.req = 1'b1; r.addr = 32'h300;
      r.wdata = MEM_rt_data;
      step(r);
      step(r);
      reset = 1'b1;
      m_errpc = '0;
      r = bubble();
      step(r);
      chk("lit_rst_req", bus_req, 32'd0);
      chk("lit_rst_rw", WB_RegWrite, 32'd0);
      run_instr(32'h74, 32'h0, 32'h0, 5'd0, 2'b00,
                1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0);
      run_instr(32'h78, 32'h300, 32'h0, 5'd9, 2'b01,
                1'b0, 1'b1, 1'b1, 1, 1'b0, 32'h1234ABCD);
      chk("lit_rst_ld", WB_wr_data, 32'h1234ABCD);

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 3);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run_instr($urandom, a, $urandom, 5'($urandom),
                   2'($urandom), k == 2, k == 1,
                   1'($urandom), $urandom_range(0, T + 1),
                   1'($urandom), $urandom);
      end

      run_instr(32'h0, 32'h0, 32'h0, 5'd0, 2'b00,
                1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
      run_instr(32'h0, 32'h0, 32'h0, 5'd0, 2'b00,
                1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

The MEM-stage load/store unit sits on the consuming side of the EX/MEM pipeline register. It takes the registered EX/MEM fields, runs a single-word data-bus transaction for loads and stores using a req/ack handshake, and stalls the upstream pipeline until that transaction finishes. It selects the write-back value and registers everything into the MEM/WB stage. It also flags misaligned accesses and bus timeouts as one-cycle errors.

## Interface
- TIMEOUT_CYCLES, 255: number of ACCESS cycles without `bus_ack` before the access is aborted; legal range 1..65535.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- MEM_PC_p4  in  32  PC+4 of the instruction in MEM
- MEM_alu_out  in  32  ALU result; this is the byte address for loads and stores
- MEM_rt_data  in  32  store data
- MEM_Rd  in  5  destination register
- MEM_MemToReg  in  2  write-back select: 00 = alu_out, 01 = memory data, 10 = PC_p4, 11 = alu_out
- MEM_MemWrite, MEM_MemRead, MEM_RegWrite  in  1 each  control
- bus_req  out  1  transaction request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  32  word-aligned address (registered)
- bus_wdata  out  32  write data (registered)
- bus_ack  in  1  transaction complete
- bus_rdata  in  32  read data, valid while `bus_ack` = 1
- stall  out  1  combinational; holds EX/MEM and all earlier stages
- WB_PC_p4, WB_alu_out, WB_mem_data, WB_wr_data  out  32 each  MEM/WB registers
- WB_Rd  out  5  MEM/WB register
- WB_MemToReg  out  2  MEM/WB register
- WB_RegWrite  out  1  MEM/WB register
- err  out  1  one-cycle pulse on a misaligned access or a timeout
- err_pc  out  32  address of the faulting instruction (`MEM_PC_p4` − 4), held until the next error

## Operation
- `mem_op` = `MEM_MemRead` | `MEM_MemWrite`. `aligned` = (`MEM_alu_out[1:0]` == 0).
- The FSM has two states, IDLE and ACCESS. A 16-bit wait counter runs in ACCESS.
- IDLE, no `mem_op`:
  - `stall` = 0.
  - The next edge loads MEM/WB from the inputs; `WB_mem_data` = 0.
- IDLE, `mem_op`, aligned:
  - `stall` = 1.
  - The edge latches `bus_addr` = {`alu_out[31:2]`, 2'b00}, `bus_wdata` = `rt_data` and `bus_we` = `MemWrite`.
  - At the same edge, `bus_req` <= 1, the counter <= 0, the FSM moves to ACCESS, and MEM/WB loads a bubble.
- IDLE, `mem_op`, misaligned:
  - No bus activity; `stall` = 0.
  - The next edge sets `err` <= 1 and `err_pc` <= `MEM_PC_p4` − 4, and MEM/WB loads a bubble.
- ACCESS, `bus_ack` = 1:
  - `stall` = 0 in that cycle.
  - The edge sets `bus_req` <= 0 and moves the FSM to IDLE.
  - At that edge MEM/WB loads the inputs with `WB_mem_data` <= `bus_rdata` (0 for a write).
- ACCESS, no ack, counter == TIMEOUT_CYCLES − 1:
  - `stall` = 0.
  - The edge sets `bus_req` <= 0, moves to IDLE, pulses `err` and sets `err_pc`; MEM/WB loads a bubble.
- ACCESS otherwise: `stall` = 1, the counter increments, and MEM/WB loads a bubble.
- A bubble is `WB_RegWrite` = 0, `WB_Rd` = 0, `WB_MemToReg` = 0, and all data fields = 0.
- `WB_wr_data` is registered and selected by `MemToReg` from `alu_out`, memory data (the `bus_rdata` at the ack cycle) or `PC_p4`.
- `RegWrite` and `Rd` are passed through unmodified; a store with `RegWrite` = 1 is not corrected here.

## Timing
- Reset values: every registered output is 0, the FSM is in IDLE, the counter is 0, and `stall` is forced to 0 while `reset` = 1.
- Non-memory instruction: MEM to WB takes 1 cycle and causes no stall.
- Aligned load or store: at least 2 cycles in MEM (issue cycle plus ack cycle) and `stall` = 1 for at least 1 cycle. Each extra bus wait cycle adds one stall cycle.
- Handshake rules:
  - `bus_req`, `bus_addr`, `bus_we` and `bus_wdata` stay stable from assertion until the edge at which `bus_ack` = 1 is sampled.
  - `bus_req` drops at that edge.
  - `bus_ack` is ignored in IDLE.
- Ack arriving in the timeout cycle: the ack wins and no error is raised.
- Back-to-back memory ops: the next op's issue cycle immediately follows the ack cycle. The bus therefore sees `bus_req` low for at least one cycle between transactions.
- Reset mid-ACCESS: `bus_req` is 0 after the reset edge, and a late ack is ignored.
- `err` is high for exactly one cycle per fault.

## Test plan
- ALU op (`MemToReg` = 00, `alu_out` = 0x1234, `Rd` = 5, `RegWrite` = 1) -> next cycle `WB_wr_data` = 0x1234, `WB_Rd` = 5, `stall` never asserted.
- Load with `alu_out` = 0x100 and ack 3 cycles after `bus_req` rises with `bus_rdata` = 0xDEADBEEF -> `bus_addr` = 0x100, `bus_we` = 0, `stall` high for 3 cycles then low in the ack cycle, then `WB_wr_data` = 0xDEADBEEF with one bubble before it per stall cycle.
- Store with `alu_out` = 0x204 and `rt_data` = 0xCAFEF00D, ack after 1 cycle -> `bus_we` = 1, `bus_wdata` = 0xCAFEF00D, `bus_req` held 1 cycle, `WB_mem_data` = 0.
- Load with `alu_out` = 0x102 and `PC_p4` = 0x40 -> `bus_req` stays 0, `err` pulses one cycle, `err_pc` = 0x3C, `WB_RegWrite` = 0.
- TIMEOUT_CYCLES = 4, no ack -> `bus_req` high for 4 cycles, then `err` = 1, `stall` releases, FSM returns to IDLE; a late ack is ignored.
- Assert reset during ACCESS -> `bus_req` = 0 and all WB outputs = 0 on the next edge; the following load completes normally.
